br_predict_unit: RTL

//  Parametrised branch resolution and prediction unit for the pipelined LEGv8 core.
//  - IF stage: reads a bimodal BHT of 2-bit saturating counters and gives a taken/not-taken prediction.
//  - EX stage: evaluates the branch from BranchOp, ConBr_type and the ALU flags, then updates the BHT.
//  - On mispredict: raises a registered flush and redirect PC one cycle later.

---
 rtl/br_predict_unit.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/br_predict_unit.sv
// Bimodal branch predictor (2-bit counters, IF-stage read) with EX-stage resolution and a registered flush/redirect.
// Optional BR_PREDICT_STATS_EN macro builds saturating branch and mispredict counters.
module br_predict_unit #(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned IDX_LSB   = 2,
  parameter logic [1:0]  CTR_INIT  = 2'b01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_taken,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              ex_pred_taken,
  input  logic [2:0]        BranchOp,
  input  logic [4:0]        ConBr_type,
  input  logic              Zero,
  input  logic              Negative,
  input  logic              Overflow,
  input  logic              Co,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [ADDR_W-1:0] alu_target,
  output logic              stall_pc,
  output logic              flush,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       br_count,
  output logic [31:0]       mispred_count
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  // BranchOp encodings shared with the control unit
  localparam logic [2:0] OP_BRANCH = 3'd1;
  localparam logic [2:0] OP_ZERO   = 3'd2;
  localparam logic [2:0] OP_NZERO  = 3'd3;
  localparam logic [2:0] OP_COND   = 3'd4;
  localparam logic [2:0] OP_ALU    = 3'd5;
  localparam logic [2:0] OP_NOINC  = 3'd6;

  // B.cond condition codes (ARM condition field numbering)
  localparam logic [4:0] COND_EQ = 5'd0;
  localparam logic [4:0] COND_NE = 5'd1;
  localparam logic [4:0] COND_CS = 5'd2;
  localparam logic [4:0] COND_CC = 5'd3;
  localparam logic [4:0] COND_HI = 5'd8;
  localparam logic [4:0] COND_LS = 5'd9;
  localparam logic [4:0] COND_GE = 5'd10;
  localparam logic [4:0] COND_LT = 5'd11;
  localparam logic [4:0] COND_GT = 5'd12;
  localparam logic [4:0] COND_LE = 5'd13;

  logic [1:0]        r_bht [BHT_DEPTH];
  logic              r_flush;
  logic [ADDR_W-1:0] r_redirect_pc;

  logic [IDX_W-1:0]  w_if_idx;
  logic [IDX_W-1:0]  w_ex_idx;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic              w_eff_valid;
  logic              w_cond_taken;
  logic              w_taken;
  logic              w_is_cond;
  logic              w_is_br;
  logic              w_mispredict;
  logic              w_set_flush;
  logic [ADDR_W-1:0] w_redirect_nxt;
  logic [1:0]        w_ctr_cur;
  logic [1:0]        w_ctr_nxt;
  logic              w_unused_pc_bits;

  assign w_if_idx    = if_pc[IDX_LSB +: IDX_W];
  assign w_ex_idx    = ex_pc[IDX_LSB +: IDX_W];
  assign w_pc_plus4  = ex_pc + ADDR_W'(4);
  assign w_eff_valid = ex_valid & ~r_flush;
  assign w_set_flush = w_eff_valid & w_mispredict;

  assign w_unused_pc_bits = ^if_pc;

  assign pred_taken  = r_bht[w_if_idx][1] & if_valid;
  assign stall_pc    = ex_valid & (BranchOp == OP_NOINC);
  assign flush       = r_flush;
  assign redirect_pc = r_redirect_pc;

  // B.cond evaluation from the NZCV flags
  always_comb begin
    w_cond_taken = 1'b0;
    case (ConBr_type)
      COND_EQ: w_cond_taken = Zero;
      COND_NE: w_cond_taken = ~Zero;
      COND_CS: w_cond_taken = Co;
      COND_CC: w_cond_taken = ~Co;
      COND_HI: w_cond_taken = Co & ~Zero;
      COND_LS: w_cond_taken = ~(Co & ~Zero);
      COND_GE: w_cond_taken = (Negative == Overflow);
      COND_LT: w_cond_taken = (Negative != Overflow);
      COND_GT: w_cond_taken = ~Zero & (Negative == Overflow);
      COND_LE: w_cond_taken = Zero | (Negative != Overflow);
      default: w_cond_taken = 1'b0;
    endcase
  end

  // Branch outcome, mispredict detection and redirect target selection
  always_comb begin
    w_taken        = 1'b0;
    w_is_cond      = 1'b0;
    w_is_br        = 1'b0;
    w_mispredict   = 1'b0;
    w_redirect_nxt = r_redirect_pc;
    case (BranchOp)
      OP_BRANCH: begin
        w_taken        = 1'b1;
        w_is_br        = 1'b1;
        w_mispredict   = ~ex_pred_taken;
        w_redirect_nxt = br_target;
      end
      OP_ZERO: begin
        w_taken   = Zero;
        w_is_cond = 1'b1;
        w_is_br   = 1'b1;
      end
      OP_NZERO: begin
        w_taken   = ~Zero;
        w_is_cond = 1'b1;
        w_is_br   = 1'b1;
      end
      OP_COND: begin
        w_taken   = w_cond_taken;
        w_is_cond = 1'b1;
        w_is_br   = 1'b1;
      end
      OP_ALU: begin
        w_taken        = 1'b1;
        w_is_br        = 1'b1;
        w_mispredict   = 1'b1;
        w_redirect_nxt = alu_target;
      end
      default: begin
        w_taken = 1'b0;
      end
    endcase
    if (w_is_cond) begin
      w_mispredict   = (w_taken != ex_pred_taken);
      w_redirect_nxt = w_taken ? br_target : w_pc_plus4;
    end
  end

  // Saturating 2-bit counter step for the EX-stage entry
  always_comb begin
    w_ctr_cur = r_bht[w_ex_idx];
    w_ctr_nxt = w_ctr_cur;
    if (w_taken) begin
      if (w_ctr_cur != 2'b11) w_ctr_nxt = w_ctr_cur + 2'd1;
    end else begin
      if (w_ctr_cur != 2'b00) w_ctr_nxt = w_ctr_cur - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush       <= 1'b0;
      r_redirect_pc <= '0;
      for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
        r_bht[IDX_W'(i)] <= CTR_INIT;
      end
    end else begin
      r_flush <= w_set_flush;
      if (w_set_flush) r_redirect_pc <= w_redirect_nxt;
      if (w_eff_valid && w_is_cond) r_bht[w_ex_idx] <= w_ctr_nxt;
    end
  end

`ifdef BR_PREDICT_STATS_EN
  logic [31:0] r_br_count;
  logic [31:0] r_mispred_count;

  // Saturating statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_count      <= '0;
      r_mispred_count <= '0;
    end else begin
      if (w_eff_valid && w_is_br && (r_br_count != 32'hFFFF_FFFF))
        r_br_count <= r_br_count + 32'd1;
      if (w_set_flush && (r_mispred_count != 32'hFFFF_FFFF))
        r_mispred_count <= r_mispred_count + 32'd1;
    end
  end

  assign br_count      = r_br_count;
  assign mispred_count = r_mispred_count;
`else
  assign br_count      = '0;
  assign mispred_count = '0;
`endif

endmodule
